// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared load-unit definitions for the RV32I pipeline: load-size
//               encodings, load-unit FSM state type and the timeout-counter
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

  // Load-size encodings as presented by the execute stage (2'b11 acts as word)
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  // Load-unit FSM states
  typedef enum logic [1:0] {
    LU_IDLE  = 2'd0,
    LU_WAIT  = 2'd1,
    LU_DRAIN = 2'd2
  } lu_state_e;

  localparam int LU_TIMEOUT_DEFAULT = 16;

  // Timeout counter width: $clog2(TIMEOUT_CYCLES), never narrower than one bit
  function automatic int lu_cnt_width(input int timeout_cycles);
    return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_load_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_load_unit_if
// Description : Request / data-memory / result bundle of the load unit.
//               master = execute stage + data memory side, slave = load unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface msrv32_load_unit_if;
  logic        load_req_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  addr_lsb_in;
  logic        flush_in;
  logic [31:0] dmdata_in;
  logic        dmack_in;
  logic [31:0] lu_output_out;
  logic        lu_valid_out;
  logic        lu_stall_out;
  logic        misaligned_load_out;
  logic        load_fault_out;

  modport master (
    output load_req_in, load_size_in, load_unsigned_in, addr_lsb_in,
           flush_in, dmdata_in, dmack_in,
    input  lu_output_out, lu_valid_out, lu_stall_out,
           misaligned_load_out, load_fault_out
  );

  modport slave (
    input  load_req_in, load_size_in, load_unsigned_in, addr_lsb_in,
           flush_in, dmdata_in, dmack_in,
    output lu_output_out, lu_valid_out, lu_stall_out,
           misaligned_load_out, load_fault_out
  );
endinterface
`default_nettype wire

// File: rtl/msrv32_lu_extract.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_lu_extract
// Description : Combinational lane select and sign/zero extension of a
//               data-memory read word for byte, half and word loads.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_lu_extract
  import msrv32_pkg::*;
(
  input  wire logic [31:0] i_data,
  input  wire logic [1:0]  i_size,
  input  wire logic        i_unsigned,
  input  wire logic [1:0]  i_offset,
  output logic      [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes
  always_comb begin
    w_byte = i_data[7:0];
    case (i_offset)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
  end

  // Extend the selected lane; word (and the 2'b11 encoding) passes through
  always_comb begin
    o_result = i_data;
    case (i_size)
      LS_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      LS_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_result = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/msrv32_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_load_unit
// Description : RV32I load unit. Checks alignment, waits for the data-memory
//               ack with a timeout, and registers the aligned/extended result
//               for the write-back mux. Stalls the pipeline while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_load_unit
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LU_TIMEOUT_DEFAULT
) (
  input  wire logic         clk_in,
  input  wire logic         rst_n_in,
  msrv32_load_unit_if.slave bus
);

  localparam int c_CNT_W = lu_cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  lu_state_e          r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]         r_size, r_off;
  logic               r_uns;
  logic [31:0]        r_lu_output;
  logic [31:0]        w_extract;
  logic               r_valid, r_mis, r_fault;
  logic               w_valid_nxt, w_mis_nxt, w_fault_nxt;
  logic               w_capture, w_misaligned, w_accept;

  // Halfwords need even addresses, words (incl. 2'b11) need 4-byte alignment
  assign w_misaligned = ((bus.load_size_in == LS_HALF) && bus.addr_lsb_in[0]) ||
                        (bus.load_size_in[1] && (bus.addr_lsb_in != 2'b00));

  assign w_accept = (r_state == LU_IDLE) && bus.load_req_in &&
                    !bus.flush_in && !w_misaligned;

  msrv32_lu_extract u_extract (
    .i_data     (bus.dmdata_in),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_offset   (r_off),
    .o_result   (w_extract)
  );

  // Next-state, timeout counting and pulse generation
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_valid_nxt = 1'b0;
    w_mis_nxt   = 1'b0;
    w_fault_nxt = 1'b0;
    case (r_state)
      LU_IDLE: begin
        if (bus.load_req_in && !bus.flush_in) begin
          if (w_misaligned) begin
            w_mis_nxt = 1'b1;
          end else begin
            w_capture   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = LU_WAIT;
          end
        end
      end
      LU_WAIT: begin
        if (bus.dmack_in) begin
          // A flush in the ack cycle discards the data
          w_valid_nxt = !bus.flush_in;
          w_state_nxt = LU_IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          // A flush racing the timeout abandons the access without a fault
          w_fault_nxt = !bus.flush_in;
          w_state_nxt = LU_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
          w_state_nxt = bus.flush_in ? LU_DRAIN : LU_WAIT;
        end
      end
      LU_DRAIN: begin
        // Swallow the outstanding ack; give up silently on timeout
        if (bus.dmack_in || (r_cnt == c_CNT_LAST)) begin
          w_state_nxt = LU_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: w_state_nxt = LU_IDLE;
    endcase
  end

  // State, counter and one-cycle pulse registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= LU_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_mis   <= w_mis_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Request attributes held for extraction when the ack arrives
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_size <= LS_BYTE;
      r_uns  <= 1'b0;
      r_off  <= 2'b00;
    end else if (w_capture) begin
      r_size <= bus.load_size_in;
      r_uns  <= bus.load_unsigned_in;
      r_off  <= bus.addr_lsb_in;
    end
  end

  // Result register changes only on a successful completion
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_lu_output <= 32'h0;
    end else if (w_valid_nxt) begin
      r_lu_output <= w_extract;
    end
  end

  assign bus.lu_output_out       = r_lu_output;
  assign bus.lu_valid_out        = r_valid;
  assign bus.misaligned_load_out = r_mis;
  assign bus.load_fault_out      = r_fault;
  assign bus.lu_stall_out        = (r_state != LU_IDLE) || w_accept;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_load_unit
// Description : Self-checking bench for msrv32_load_unit: vector table of
//               single loads plus hand-written timeout, flush, delayed-ack
//               and reset sequences; results checked through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_load_unit;
  import msrv32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  msrv32_load_unit_if bus ();
  msrv32_load_unit_if bus_t ();

  // Short-timeout instance sees the same stimulus
  assign bus_t.load_req_in      = bus.load_req_in;
  assign bus_t.load_size_in     = bus.load_size_in;
  assign bus_t.load_unsigned_in = bus.load_unsigned_in;
  assign bus_t.addr_lsb_in      = bus.addr_lsb_in;
  assign bus_t.flush_in         = bus.flush_in;
  assign bus_t.dmdata_in        = bus.dmdata_in;
  assign bus_t.dmack_in         = bus.dmack_in;

  msrv32_load_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  msrv32_load_unit #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus_t.slave)
  );

  typedef struct {
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] data;
    logic [31:0] exp;
    logic        misal;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && bus.lu_valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got %h expected no valid", bus.lu_output_out);
      end else begin
        chk("load_result", bus.lu_output_out, exp_q.pop_front());
      end
    end
  end

  // One load with request in the current cycle and ack 'delay' cycles later
  task automatic do_load(input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [31:0] data, input int delay,
                         input logic [31:0] exp, input logic misal);
    bus.load_req_in      = 1'b1;
    bus.load_size_in     = size;
    bus.load_unsigned_in = uns;
    bus.addr_lsb_in      = off;
    @(negedge clk);
    chk("req_stall", bus.lu_stall_out, {31'h0, !misal});
    tick;
    bus.load_req_in = 1'b0;
    if (misal) begin
      chk("misaligned_pulse", bus.misaligned_load_out, 1);
      chk("misaligned_stall", bus.lu_stall_out, 0);
      chk("misaligned_hold", bus.lu_output_out, last_exp);
      tick;
      chk("misaligned_end", bus.misaligned_load_out, 0);
      chk("misaligned_novalid", bus.lu_valid_out, 0);
    end else begin
      for (int i = 0; i < delay - 1; i++) begin
        chk("wait_stall", bus.lu_stall_out, 1);
        tick;
      end
      chk("ack_stall", bus.lu_stall_out, 1);
      bus.dmack_in  = 1'b1;
      bus.dmdata_in = data;
      exp_q.push_back(exp);
      last_exp = exp;
      tick;
      bus.dmack_in  = 1'b0;
      bus.dmdata_in = $urandom;
      chk("valid_pulse", bus.lu_valid_out, 1);
      chk("done_stall", bus.lu_stall_out, 0);
      tick;
      chk("valid_end", bus.lu_valid_out, 0);
    end
  endtask

  initial begin
    vecs.push_back('{LS_BYTE, 1'b0, 2'd3, 32'h80AB_CD12, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{LS_BYTE, 1'b1, 2'd3, 32'h80AB_CD12, 32'h0000_0080, 1'b0});
    vecs.push_back('{LS_BYTE, 1'b0, 2'd1, 32'h80AB_CD12, 32'hFFFF_FFCD, 1'b0});
    vecs.push_back('{LS_BYTE, 1'b1, 2'd2, 32'h80AB_CD12, 32'h0000_00AB, 1'b0});
    vecs.push_back('{LS_BYTE, 1'b0, 2'd0, 32'h80AB_CD12, 32'h0000_0012, 1'b0});
    vecs.push_back('{LS_HALF, 1'b0, 2'd2, 32'h1234_8001, 32'h0000_1234, 1'b0});
    vecs.push_back('{LS_HALF, 1'b1, 2'd0, 32'h1234_8001, 32'h0000_8001, 1'b0});
    vecs.push_back('{LS_HALF, 1'b0, 2'd0, 32'h1234_8001, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{LS_WORD, 1'b0, 2'd0, 32'h1234_8001, 32'h1234_8001, 1'b0});
    vecs.push_back('{LS_WORD, 1'b0, 2'd1, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{LS_HALF, 1'b0, 2'd1, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{LS_HALF, 1'b1, 2'd3, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{LS_WORD, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{2'b11,   1'b1, 2'd0, 32'hF000_0001, 32'hF000_0001, 1'b0});
    vecs.push_back('{2'b11,   1'b0, 2'd3, 32'h0,         32'h0,         1'b1});

    bus.load_req_in      = 1'b0;
    bus.load_size_in     = LS_BYTE;
    bus.load_unsigned_in = 1'b0;
    bus.addr_lsb_in      = 2'b00;
    bus.flush_in         = 1'b0;
    bus.dmdata_in        = 32'h0;
    bus.dmack_in         = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("reset_output", bus.lu_output_out, 32'h0);
    chk("reset_valid", bus.lu_valid_out, 0);
    chk("reset_stall", bus.lu_stall_out, 0);
    chk("reset_misaligned", bus.misaligned_load_out, 0);
    chk("reset_fault", bus.load_fault_out, 0);

    foreach (vecs[i])
      do_load(vecs[i].size, vecs[i].uns, vecs[i].off, vecs[i].data, 1,
              vecs[i].exp, vecs[i].misal);

    // Timeout on the 4-cycle instance: fault visible four edges after WAIT entry
    bus.load_req_in  = 1'b1;
    bus.load_size_in = LS_WORD;
    bus.addr_lsb_in  = 2'b00;
    tick;
    bus.load_req_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t_wait_stall", bus_t.lu_stall_out, 1);
      chk("t_no_fault_yet", bus_t.load_fault_out, 0);
      tick;
    end
    chk("t_fault_pulse", bus_t.load_fault_out, 1);
    chk("t_stall_release", bus_t.lu_stall_out, 0);
    chk("t_output_hold", bus_t.lu_output_out, last_exp);
    chk("t_no_valid", bus_t.lu_valid_out, 0);
    chk("long_timeout_still_wait", bus.lu_stall_out, 1);
    tick;
    chk("t_fault_end", bus_t.load_fault_out, 0);
    // Retire the long-timeout access with flush + ack in the same cycle
    bus.flush_in  = 1'b1;
    bus.dmack_in  = 1'b1;
    bus.dmdata_in = 32'h5555_AAAA;
    tick;
    bus.flush_in = 1'b0;
    bus.dmack_in = 1'b0;
    chk("flush_ack_novalid", bus.lu_valid_out, 0);
    chk("flush_ack_idle", bus.lu_stall_out, 0);
    chk("flush_ack_hold", bus.lu_output_out, last_exp);

    // Ack delayed five cycles
    do_load(LS_WORD, 1'b0, 2'd0, 32'hCAFE_0123, 5, 32'hCAFE_0123, 1'b0);

    // Flush together with the request drops it
    bus.load_req_in = 1'b1;
    bus.flush_in    = 1'b1;
    @(negedge clk);
    chk("flush_req_stall", bus.lu_stall_out, 0);
    tick;
    bus.load_req_in = 1'b0;
    bus.flush_in    = 1'b0;
    chk("flush_req_idle", bus.lu_stall_out, 0);
    bus.dmack_in  = 1'b1;
    bus.dmdata_in = 32'h1111_2222;
    tick;
    bus.dmack_in = 1'b0;
    chk("flush_req_novalid", bus.lu_valid_out, 0);

    // Flush at N+2 during WAIT, ack at N+4, back in IDLE at N+5
    bus.load_req_in  = 1'b1;
    bus.load_size_in = LS_WORD;
    bus.addr_lsb_in  = 2'b00;
    tick;
    bus.load_req_in = 1'b0;
    chk("flushw_n1_stall", bus.lu_stall_out, 1);
    tick;
    bus.flush_in = 1'b1;
    tick;
    bus.flush_in = 1'b0;
    chk("drain_stall", bus.lu_stall_out, 1);
    tick;
    bus.dmack_in  = 1'b1;
    bus.dmdata_in = 32'h7777_8888;
    chk("drain_ack_stall", bus.lu_stall_out, 1);
    tick;
    bus.dmack_in = 1'b0;
    chk("drain_novalid", bus.lu_valid_out, 0);
    chk("drain_idle", bus.lu_stall_out, 0);
    chk("drain_hold", bus.lu_output_out, last_exp);
    do_load(LS_BYTE, 1'b0, 2'd2, 32'h00FE_0000, 1, 32'hFFFF_FFFE, 1'b0);

    // Asynchronous reset in the middle of WAIT
    bus.load_req_in  = 1'b1;
    bus.load_size_in = LS_WORD;
    bus.addr_lsb_in  = 2'b00;
    tick;
    bus.load_req_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    last_exp = 32'h0;
    chk("arst_output", bus.lu_output_out, 32'h0);
    chk("arst_stall", bus.lu_stall_out, 0);
    chk("arst_valid", bus.lu_valid_out, 0);
    chk("arst_misaligned", bus.misaligned_load_out, 0);
    chk("arst_fault", bus.load_fault_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    bus.dmack_in  = 1'b1;
    bus.dmdata_in = 32'h9999_9999;
    tick;
    bus.dmack_in = 1'b0;
    chk("stray_ack_novalid", bus.lu_valid_out, 0);
    chk("stray_ack_stall", bus.lu_stall_out, 0);
    chk("stray_ack_output", bus.lu_output_out, 32'h0);
    tick;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
